// File: rtl/bus_arbiter_if.sv
// Bundle of the two master request/response channels and the shared slave
// channel of bus_arbiter. The "master" modport is the arbiter's own view (it
// masters the shared memory bus); the "slave" modport is the view of
// everything around it (the two requesting masters and the memory slave).
interface bus_arbiter_if;
  // Instruction-fetch master
  logic        m0_req_i;
  logic        m0_we_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wdata_i;
  logic [31:0] m0_rdata_o;
  logic        m0_ack_o;

  // Load/store master
  logic        m1_req_i;
  logic        m1_we_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic [31:0] m1_rdata_o;
  logic        m1_ack_o;

  // Shared memory slave
  logic        s_req_o;
  logic        s_we_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic [31:0] s_rdata_i;
  logic        s_ack_i;

  modport master (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m0_rdata_o, m0_ack_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output m1_rdata_o, m1_ack_o,
    output s_req_o, s_we_o, s_addr_o, s_wdata_o,
    input  s_rdata_i, s_ack_i
  );

  modport slave (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m0_rdata_o, m0_ack_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  m1_rdata_o, m1_ack_o,
    input  s_req_o, s_we_o, s_addr_o, s_wdata_o,
    output s_rdata_i, s_ack_i
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter in front of one memory slave.
// m0 = instruction fetch, m1 = load/store. One transaction at a time, with an
// IDLE arbitration cycle between grants. The slave channel is combinationally
// steered from the granted master.
//
// Optional feature: define BUS_ARBITER_TIMEOUT_EN to enable the slave-wait
// watchdog. After TIMEOUT_CYCLES un-acked grant cycles the granted master gets
// a forced ack carrying 32'hDEAD_BEEF and err_o pulses for that cycle. Without
// the macro the arbiter waits forever for s_ack_i and err_o is tied to 0.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_arbiter_if.master bus,
  output logic          hold_flag_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state_reg;
  logic   last_grant_reg;   // index of the master granted most recently

  // Per-master views so both channels share one description
  logic [1:0]  req_vec;
  logic [1:0]  we_vec;
  logic [31:0] addr_vec  [2];
  logic [31:0] wdata_vec [2];
  logic [1:0]  grant_vec;
  logic [1:0]  ack_vec;
  logic [31:0] rdata_vec [2];

  logic granted_idx;        // which master the current GRANT state belongs to
  logic active;             // granted master is still requesting
  logic timeout_hit;        // watchdog expiry in this cycle

  assign req_vec      = {bus.m1_req_i, bus.m0_req_i};
  assign we_vec       = {bus.m1_we_i,  bus.m0_we_i};
  assign addr_vec[0]  = bus.m0_addr_i;
  assign addr_vec[1]  = bus.m1_addr_i;
  assign wdata_vec[0] = bus.m0_wdata_i;
  assign wdata_vec[1] = bus.m1_wdata_i;

  assign granted_idx = (state_reg == GRANT1);
  // A master dropping its request mid-grant immediately releases the slave.
  assign active      = (state_reg != IDLE) && req_vec[granted_idx];

  // Slave request is a pure decode of the state; all zero in IDLE or on abort
  assign bus.s_req_o   = active;
  assign bus.s_we_o    = active & we_vec[granted_idx];
  assign bus.s_addr_o  = active ? addr_vec[granted_idx]  : '0;
  assign bus.s_wdata_o = active ? wdata_vec[granted_idx] : '0;

  // Response steering: only the granted, still-requesting master sees an ack.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    localparam state_t GRANT_STATE = (gi == 0) ? GRANT0 : GRANT1;
    assign grant_vec[gi] = (state_reg == GRANT_STATE);
    assign ack_vec[gi]   = grant_vec[gi] & req_vec[gi] & (bus.s_ack_i | timeout_hit);
    assign rdata_vec[gi] = grant_vec[gi] ? (timeout_hit ? 32'hDEAD_BEEF : bus.s_rdata_i) : '0;
  end

  assign bus.m0_ack_o   = ack_vec[0];
  assign bus.m1_ack_o   = ack_vec[1];
  assign bus.m0_rdata_o = rdata_vec[0];
  assign bus.m1_rdata_o = rdata_vec[1];

  // Stall the pipeline while any master has an outstanding, un-acked request
  assign hold_flag_o = (bus.m0_req_i & ~bus.m0_ack_o) | (bus.m1_req_i & ~bus.m1_ack_o);

  // A zero timeout would leave no cycle for the slave to answer
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_reg;

  // A real ack in the expiry cycle wins over the forced one
  assign timeout_hit = active & ~bus.s_ack_i & (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES));
  assign err_o       = timeout_hit;

  // Count consecutive grant cycles without an ack; clear on ack, expiry or exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
    end else if (active && !bus.s_ack_i && !timeout_hit) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end else begin
      tmo_cnt_reg <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  // Arbitration FSM: round-robin on ties, back to IDLE after every transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;   // m0 wins the first tie after reset
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_vec[0] && (!req_vec[1] || last_grant_reg)) begin
            state_reg      <= GRANT0;
            last_grant_reg <= 1'b0;
          end else if (req_vec[1]) begin
            state_reg      <= GRANT1;
            last_grant_reg <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (!active || bus.s_ack_i || timeout_hit) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter. A behavioural slave with programmable
// latency answers the shared channel; expected responses are queued when a
// request is issued and matched by the ack monitor in order.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold_flag;
  logic err;

  always #5 clk = ~clk;

  bus_arbiter_if bif();

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bif.master),
    .hold_flag_o(hold_flag),
    .err_o      (err)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        mst;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  // Memory contents seen by the masters
  function automatic logic [31:0] rdata_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : ((a ^ 32'hA5A5_0000) + 32'd7);
  endfunction

  // ---------------- behavioural slave ----------------
  int          slave_lat = 1;
  bit          slave_en = 1'b1;
  int          wait_cnt = 0;
  logic        slv_we;
  logic [31:0] slv_addr;
  logic [31:0] slv_wdata;

  initial begin
    bif.s_ack_i   = 1'b0;
    bif.s_rdata_i = '0;
    slv_we        = 1'b0;
    slv_addr      = '0;
    slv_wdata     = '0;
    forever begin
      @(posedge clk);
      #2;
      bif.s_ack_i   = 1'b0;
      bif.s_rdata_i = '0;
      if (slave_en && bif.s_req_o) begin
        if (wait_cnt >= slave_lat) begin
          bif.s_ack_i   = 1'b1;
          bif.s_rdata_i = rdata_fn(bif.s_addr_o);
          slv_we        = bif.s_we_o;
          slv_addr      = bif.s_addr_o;
          slv_wdata     = bif.s_wdata_o;
          wait_cnt      = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- ack monitor / scoreboard ----------------
  logic        mon_mst;
  logic [31:0] mon_d;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.m0_ack_o && bif.m1_ack_o) begin
        n_cmp++;
        n_err++;
        $display("FAIL dual_ack: both masters acked in one cycle at %0t", $time);
      end else if (bif.m0_ack_o || bif.m1_ack_o) begin
        mon_mst = bif.m1_ack_o;
        mon_d   = mon_mst ? bif.m1_rdata_o : bif.m0_rdata_o;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_ack: m%0d rdata=%h with nothing expected", mon_mst, mon_d);
        end else begin
          mon_e = sb.pop_front();
          if (mon_mst !== mon_e.mst || mon_d !== mon_e.rdata) begin
            n_err++;
            $display("FAIL ack_order: got m%0d rdata=%h, expected m%0d rdata=%h",
                     mon_mst, mon_d, mon_e.mst, mon_e.rdata);
          end else begin
            $display("ack m%0d rdata=%h ok", mon_mst, mon_d);
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    bif.m0_req_i = 1'b0; bif.m0_we_i = 1'b0; bif.m0_addr_i = '0; bif.m0_wdata_i = '0;
    bif.m1_req_i = 1'b0; bif.m1_we_i = 1'b0; bif.m1_addr_i = '0; bif.m1_wdata_i = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bif.m0_req_i  = 1'b1;
    bif.m0_addr_i = 32'h40;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bif.s_req_o !== 1'b0 || bif.s_addr_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_slave: s_req=%b s_addr=%h, expected 0/0", bif.s_req_o, bif.s_addr_o);
    end
    n_cmp++;
    if ({bif.m0_ack_o, bif.m1_ack_o, err} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ack_err: acks/err=%b, expected 000", {bif.m0_ack_o, bif.m1_ack_o, err});
    end
    n_cmp++;
    if (hold_flag !== 1'b1) begin
      n_err++;
      $display("FAIL reset_hold_req: hold=%b, expected 1", hold_flag);
    end
    bif.m0_req_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (hold_flag !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold_idle: hold=%b, expected 0", hold_flag);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_lone_fetch();
    slave_lat = 1;
    @(posedge clk);
    #1;
    bif.m0_req_i  = 1'b1;
    bif.m0_we_i   = 1'b0;
    bif.m0_addr_i = 32'h100;
    sb.push_back('{mst: 1'b0, rdata: 32'h13});
    @(negedge clk);                       // cycle 0: still arbitrating
    n_cmp++;
    if (bif.s_req_o !== 1'b0 || hold_flag !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_c0: s_req=%b hold=%b, expected 0/1", bif.s_req_o, hold_flag);
    end
    @(negedge clk);                       // cycle 1: granted
    n_cmp++;
    if (bif.s_req_o !== 1'b1 || bif.s_addr_o !== 32'h100 || bif.s_we_o !== 1'b0 || bif.m0_ack_o !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_c1: s_req=%b addr=%h we=%b ack=%b, expected 1/00000100/0/0",
               bif.s_req_o, bif.s_addr_o, bif.s_we_o, bif.m0_ack_o);
    end
    @(negedge clk);                       // cycle 2: slave acks
    n_cmp++;
    if (bif.m0_ack_o !== 1'b1 || bif.m0_rdata_o !== 32'h13 || hold_flag !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_c2: ack=%b rdata=%h hold=%b, expected 1/00000013/0",
               bif.m0_ack_o, bif.m0_rdata_o, hold_flag);
    end
    @(negedge clk);                       // cycle 3: back in IDLE, req still high
    n_cmp++;
    if (bif.s_req_o !== 1'b0 || bif.m0_ack_o !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_c3_idle: s_req=%b ack=%b, expected 0/0", bif.s_req_o, bif.m0_ack_o);
    end
    @(posedge clk);
    #1 bif.m0_req_i = 1'b0;
    repeat (2) @(posedge clk);
    $display("test_lone_fetch done");
  endtask

  task automatic test_contention();
    int n0 = 0;
    int n1 = 0;
    bit finished = 1'b0;
    slave_lat = 1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    bif.m0_req_i = 1'b1; bif.m0_addr_i = 32'h1000;
    bif.m1_req_i = 1'b1; bif.m1_addr_i = 32'h3000;
    sb.push_back('{mst: 1'b0, rdata: rdata_fn(32'h1000)});
    sb.push_back('{mst: 1'b1, rdata: rdata_fn(32'h3000)});
    sb.push_back('{mst: 1'b0, rdata: rdata_fn(32'h1004)});
    sb.push_back('{mst: 1'b1, rdata: rdata_fn(32'h3004)});
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
      @(negedge clk);
      if (bif.m0_ack_o) n0++;
      if (bif.m1_ack_o) n1++;
      n_cmp++;
      if (n0 + n1 == 4) begin
        finished = 1'b1;
        if (hold_flag !== 1'b0) begin
          n_err++;
          $display("FAIL contention_hold_end: hold=%b, expected 0", hold_flag);
        end
      end else if (hold_flag !== 1'b1) begin
        n_err++;
        $display("FAIL contention_hold: cycle %0d hold=%b, expected 1", cyc, hold_flag);
      end
      @(posedge clk);
      #1;
      bif.m0_addr_i = 32'h1000 + 32'(4 * n0);
      bif.m1_addr_i = 32'h3000 + 32'(4 * n1);
      bif.m0_req_i  = (n0 < 2);
      bif.m1_req_i  = (n1 < 2);
    end
    n_cmp++;
    if (!finished) begin
      n_err++;
      $display("FAIL contention_timeout: %0d acks seen, expected 4", n0 + n1);
    end
    idle_inputs();
    repeat (2) @(posedge clk);
    $display("test_contention done");
  endtask

  task automatic test_write();
    bit got = 1'b0;
    slave_lat = 2;
    @(posedge clk);
    #1;
    bif.m1_req_i   = 1'b1;
    bif.m1_we_i    = 1'b1;
    bif.m1_addr_i  = 32'h2000;
    bif.m1_wdata_i = 32'hCAFE0001;
    sb.push_back('{mst: 1'b1, rdata: rdata_fn(32'h2000)});
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bif.m1_ack_o;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL write_ack: no m1_ack within 20 cycles");
    end
    n_cmp++;
    if (bif.s_we_o !== 1'b1 || bif.s_addr_o !== 32'h2000 || bif.s_wdata_o !== 32'hCAFE0001) begin
      n_err++;
      $display("FAIL write_bus: we=%b addr=%h wdata=%h, expected 1/00002000/cafe0001",
               bif.s_we_o, bif.s_addr_o, bif.s_wdata_o);
    end
    n_cmp++;
    if (slv_we !== 1'b1 || slv_addr !== 32'h2000 || slv_wdata !== 32'hCAFE0001) begin
      n_err++;
      $display("FAIL write_slave: we=%b addr=%h wdata=%h, expected 1/00002000/cafe0001",
               slv_we, slv_addr, slv_wdata);
    end
    @(posedge clk);
    #1 idle_inputs();
    repeat (2) @(posedge clk);
    $display("test_write done");
  endtask

  task automatic test_req_drop();
    bit got = 1'b0;
    slave_lat = 3;
    @(posedge clk);
    #1;
    bif.m0_req_i  = 1'b1;
    bif.m0_addr_i = 32'h500;
    @(negedge clk);                       // cycle 0
    @(posedge clk);
    #1;
    bif.m1_req_i  = 1'b1;
    bif.m1_addr_i = 32'h600;
    sb.push_back('{mst: 1'b1, rdata: rdata_fn(32'h600)});
    @(negedge clk);                       // cycle 1: m0 granted
    n_cmp++;
    if (bif.s_req_o !== 1'b1 || bif.s_addr_o !== 32'h500) begin
      n_err++;
      $display("FAIL drop_grant0: s_req=%b addr=%h, expected 1/00000500", bif.s_req_o, bif.s_addr_o);
    end
    @(posedge clk);
    #1 bif.m0_req_i = 1'b0;
    @(negedge clk);                       // cycle 2: dropped in grant
    n_cmp++;
    if (bif.s_req_o !== 1'b0 || bif.m0_ack_o !== 1'b0) begin
      n_err++;
      $display("FAIL drop_same_cycle: s_req=%b m0_ack=%b, expected 0/0", bif.s_req_o, bif.m0_ack_o);
    end
    @(negedge clk);                       // cycle 3: IDLE, m1 still pending
    n_cmp++;
    if (bif.s_req_o !== 1'b0 || hold_flag !== 1'b1) begin
      n_err++;
      $display("FAIL drop_idle: s_req=%b hold=%b, expected 0/1", bif.s_req_o, hold_flag);
    end
    @(negedge clk);                       // cycle 4: m1 granted
    n_cmp++;
    if (bif.s_req_o !== 1'b1 || bif.s_addr_o !== 32'h600) begin
      n_err++;
      $display("FAIL drop_grant1: s_req=%b addr=%h, expected 1/00000600", bif.s_req_o, bif.s_addr_o);
    end
    got = bif.m1_ack_o;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bif.m1_ack_o;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL drop_m1_ack: no m1_ack within 20 cycles");
    end
    @(posedge clk);
    #1 idle_inputs();
    repeat (2) @(posedge clk);
    $display("test_req_drop done");
  endtask

  task automatic test_timeout();
    int pulses = 0;
    slave_en = 1'b0;
    @(posedge clk);
    #1;
    bif.m0_req_i  = 1'b1;
    bif.m0_addr_i = 32'h700;
`ifdef BUS_ARBITER_TIMEOUT_EN
    sb.push_back('{mst: 1'b0, rdata: 32'hDEAD_BEEF});
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (err === 1'b1) pulses++;
      n_cmp++;
      if (err !== (k == 5)) begin
        n_err++;
        $display("FAIL timeout_err: cycle %0d err=%b, expected %b", k, err, (k == 5));
      end
      if (k == 5) begin
        n_cmp++;
        if (bif.m0_ack_o !== 1'b1 || bif.m0_rdata_o !== 32'hDEAD_BEEF) begin
          n_err++;
          $display("FAIL timeout_ack: ack=%b rdata=%h, expected 1/deadbeef", bif.m0_ack_o, bif.m0_rdata_o);
        end
        @(posedge clk);
        #1 bif.m0_req_i = 1'b0;
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL timeout_pulses: %0d err pulses, expected 1", pulses);
    end
`else
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (err === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || bif.s_req_o !== 1'b1 || bif.m0_ack_o !== 1'b0) begin
      n_err++;
      $display("FAIL no_timeout: err pulses=%0d s_req=%b ack=%b, expected 0/1/0",
               pulses, bif.s_req_o, bif.m0_ack_o);
    end
    @(posedge clk);
    #1 bif.m0_req_i = 1'b0;
`endif
    repeat (2) @(posedge clk);
    slave_en = 1'b1;
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    slave_lat = 3;
    @(posedge clk);
    #1;
    bif.m1_req_i  = 1'b1;
    bif.m1_addr_i = 32'h800;
    @(negedge clk);                       // cycle 0
    @(negedge clk);                       // cycle 1: GRANT1
    n_cmp++;
    if (bif.s_req_o !== 1'b1 || bif.s_addr_o !== 32'h800) begin
      n_err++;
      $display("FAIL rstmid_grant1: s_req=%b addr=%h, expected 1/00000800", bif.s_req_o, bif.s_addr_o);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bif.s_req_o, bif.s_we_o, bif.m1_ack_o, bif.m0_ack_o, err} !== 5'b0 ||
        bif.s_addr_o !== 32'h0 || bif.m1_rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_async: s_req=%b addr=%h m1_ack=%b m1_rdata=%h err=%b, expected all 0",
               bif.s_req_o, bif.s_addr_o, bif.m1_ack_o, bif.m1_rdata_o, err);
    end
    bif.m0_req_i  = 1'b1;
    bif.m0_addr_i = 32'h900;
    sb.push_back('{mst: 1'b0, rdata: rdata_fn(32'h900)});
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);                       // cycle 0 after release: IDLE
    @(negedge clk);                       // cycle 1: tie goes to m0
    n_cmp++;
    if (bif.s_req_o !== 1'b1 || bif.s_addr_o !== 32'h900) begin
      n_err++;
      $display("FAIL rstmid_tie: s_req=%b addr=%h, expected 1/00000900", bif.s_req_o, bif.s_addr_o);
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bif.m0_ack_o;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL rstmid_m0_ack: no m0_ack within 20 cycles");
    end
    @(posedge clk);
    #1 idle_inputs();
    repeat (2) @(posedge clk);
    $display("test_reset_mid done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_lone_fetch();
    test_contention();
    test_write();
    test_req_drop();
    test_timeout();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: %0d expected acks never seen, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
